nkmd_prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the nkmd CPU's program memory. It accepts a framed byte stream from a host link, assembles 32-bit instruction words, and writes them into program RAM through a write port. It holds the CPU in reset until a complete, checksum-valid image has been written. It replaces the fixed program ROM as the source of `p_data_i` contents and drives the CPU's `rst` input.

---
 rtl/nkmd_loader_pkg.sv | 17 +
 rtl/nkmd_word_assembler.sv | 35 +++
 rtl/nkmd_prog_loader.sv | 155 +++++++++++++++
 tb/tb_nkmd_prog_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nkmd_loader_pkg.sv
// Shared constants and state encoding for the nkmd boot-time program loader.
package nkmd_loader_pkg;

  localparam logic [7:0] LOADER_MAGIC   = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

endpackage

// File: rtl/nkmd_word_assembler.sv
// Shifts host bytes MSB-first into a 32-bit word; flags the 4th byte of each word.
module nkmd_word_assembler
  import nkmd_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_i,
  input  logic        strobe_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  // The completed word includes the byte arriving this cycle, so the top can register it directly.
  assign word_o      = {shift_q, byte_i};
  assign word_done_o = strobe_i & (cnt_q == 2'(BYTES_PER_WORD - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (strobe_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/nkmd_prog_loader.sv
// Framed-byte program loader for nkmd program RAM; holds the CPU in reset until loaded.
// Define NKMD_PROG_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module nkmd_prog_loader
  import nkmd_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              reload_i,
  output logic              prog_we_o,
  output logic [ADDR_W-1:0] prog_addr_o,
  output logic [31:0]       prog_data_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CW = ADDR_W + 1;

  loader_state_e     state_q;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [ADDR_W-1:0] addr_q;
  logic              in_ready_q, prog_we_q, cpu_rst_q, done_q, err_q;
  logic [ADDR_W-1:0] prog_addr_q;
  logic [31:0]       prog_data_q;
`ifdef NKMD_PROG_LOADER_CSUM_EN
  logic [7:0]        csum_q;
`endif

  logic        xfer;
  logic [15:0] len_n;
  logic        len_bad;
  logic        last_word;
  logic        asm_strobe, asm_clear, word_done;
  logic [31:0] word;

  assign xfer      = in_valid_i & in_ready_q;
  assign len_n     = {len_hi_q, in_data_i};
  assign len_bad   = (len_n == 16'd0) || (32'(len_n) > (32'd1 << ADDR_W));
  // Compare one bit wider so N == 2^ADDR_W terminates before the address wraps.
  assign last_word = (({1'b0, addr_q} + CW'(1)) == CW'(len_q));

  // A reload drops any partial word and the byte transferring alongside it.
  assign asm_strobe = xfer & ~reload_i & (state_q == ST_DATA);
  assign asm_clear  = reload_i | (state_q != ST_DATA);

  nkmd_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_i     (in_data_i),
    .strobe_i   (asm_strobe),
    .clear_i    (asm_clear),
    .word_o     (word),
    .word_done_o(word_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_hi_q    <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      in_ready_q  <= 1'b1;
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef NKMD_PROG_LOADER_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      prog_we_q <= 1'b0;
      if (reload_i) begin
        state_q    <= ST_IDLE;
        in_ready_q <= 1'b1;
        cpu_rst_q  <= 1'b1;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
      end else if (xfer) begin
        unique case (state_q)
          ST_IDLE: if (in_data_i == LOADER_MAGIC) state_q <= ST_LEN_HI;
          ST_LEN_HI: begin
            len_hi_q <= in_data_i;
            state_q  <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            if (len_bad) begin
              state_q    <= ST_ERR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              len_q   <= len_n;
              addr_q  <= '0;
              state_q <= ST_DATA;
`ifdef NKMD_PROG_LOADER_CSUM_EN
              csum_q  <= '0;
`endif
            end
          end
          ST_DATA: begin
`ifdef NKMD_PROG_LOADER_CSUM_EN
            csum_q <= csum_q ^ in_data_i;
`endif
            if (word_done) begin
              prog_we_q   <= 1'b1;
              prog_addr_q <= addr_q;
              prog_data_q <= word;
              addr_q      <= addr_q + 1'b1;
              if (last_word) begin
`ifdef NKMD_PROG_LOADER_CSUM_EN
                state_q    <= ST_CSUM;
`else
                state_q    <= ST_DONE;
                in_ready_q <= 1'b0;
                done_q     <= 1'b1;
                cpu_rst_q  <= 1'b0;
`endif
              end
            end
          end
`ifdef NKMD_PROG_LOADER_CSUM_EN
          ST_CSUM: begin
            in_ready_q <= 1'b0;
            if (in_data_i == csum_q) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign prog_we_o   = prog_we_q;
  assign prog_addr_o = prog_addr_q;
  assign prog_data_o = prog_data_q;
  assign cpu_rst_o   = cpu_rst_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_nkmd_prog_loader.sv
// Directed self-checking bench for nkmd_prog_loader (follows NKMD_PROG_LOADER_CSUM_EN).
module tb_nkmd_prog_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        in_data_i = '0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic              reload_i = 1'b0;
  logic              prog_we_o;
  logic [ADDR_W-1:0] prog_addr_o;
  logic [31:0]       prog_data_o;
  logic              cpu_rst_o, done_o, err_o;

  nkmd_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .reload_i   (reload_i),
    .prog_we_o  (prog_we_o),
    .prog_addr_o(prog_addr_o),
    .prog_data_o(prog_data_o),
    .cpu_rst_o  (cpu_rst_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0]       frame_words [1024];
  logic [7:0]        last_csum;
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [31:0]       wr_data_q [$];

  always @(negedge clk) begin
    if (prog_we_o) begin
      wr_addr_q.push_back(prog_addr_o);
      wr_data_q.push_back(prog_data_o);
    end
  end

  // {in_ready, we, addr, data, cpu_rst, done, err}
  localparam logic [46:0] RESET_VEC = {1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0};

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data_i  = b;
    in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic pulse_reload();
    reload_i = 1'b1;
    @(posedge clk);
    #1;
    reload_i = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Sends magic, length and n words; the checksum byte is left to the caller.
  task automatic send_frame(input int n, input int gap, input bit check_lat);
    logic [7:0]  b;
    logic [15:0] n16;
    n16 = 16'(n);
    last_csum = '0;
    send_byte(8'hA5);   idle(gap);
    send_byte(n16[15:8]); idle(gap);
    send_byte(n16[7:0]);  idle(gap);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = frame_words[w][31-8*k -: 8];
        last_csum ^= b;
        send_byte(b);
        if (k == 3 && check_lat) begin
          n_total++;
          if (prog_we_o !== 1'b1 || prog_addr_o !== ADDR_W'(w) || prog_data_o !== frame_words[w])
            $display("FAIL write_latency w%0d: we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                     w, prog_we_o, prog_addr_o, prog_data_o, w, frame_words[w]);
          else n_pass++;
        end
        idle(gap);
      end
    end
  endtask

  task automatic finish_frame();
`ifdef NKMD_PROG_LOADER_CSUM_EN
    send_byte(last_csum);
`endif
  endtask

  task automatic check_done(input string name);
    n_total++;
    if ({done_o, cpu_rst_o, in_ready_o, err_o} !== 4'b1000)
      $display("FAIL %s: done=%b cpu_rst=%b in_ready=%b err=%b, want 1 0 0 0",
               name, done_o, cpu_rst_o, in_ready_o, err_o);
    else n_pass++;
  endtask

  task automatic check_two_writes(input string name);
    n_total++;
    if (wr_addr_q.size() != 2)
      $display("FAIL %s_count: writes=%0d, want 2", name, wr_addr_q.size());
    else if (wr_addr_q[0] !== 10'd0 || wr_data_q[0] !== 32'h01020304 ||
             wr_addr_q[1] !== 10'd1 || wr_data_q[1] !== 32'hDEADBEEF)
      $display("FAIL %s_data: %0d=%h %0d=%h, want 0=01020304 1=deadbeef",
               name, wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
    else n_pass++;
  endtask

  task automatic load_std_words();
    frame_words[0] = 32'h01020304;
    frame_words[1] = 32'hDEADBEEF;
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if ({in_ready_o, prog_we_o, prog_addr_o, prog_data_o, cpu_rst_o, done_o, err_o} !== RESET_VEC)
      $display("FAIL reset_values: got %h, want %h",
               {in_ready_o, prog_we_o, prog_addr_o, prog_data_o, cpu_rst_o, done_o, err_o}, RESET_VEC);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clear_log();
    load_std_words();
    send_frame(2, 0, 1'b1);
`ifndef NKMD_PROG_LOADER_CSUM_EN
    n_total++;
    if (!(done_o === 1'b1 && prog_we_o === 1'b1))
      $display("FAIL done_with_last_write: done=%b we=%b, want 1 1", done_o, prog_we_o);
    else n_pass++;
`endif
    finish_frame();
    check_done("basic_done");
    idle(2);
    check_two_writes("basic_writes");
    send_byte(8'hA5);
    idle(2);
    n_total++;
    if (wr_addr_q.size() != 2 || done_o !== 1'b1)
      $display("FAIL ignore_after_done: writes=%0d done=%b, want 2 1", wr_addr_q.size(), done_o);
    else n_pass++;
    pulse_reload();
    n_total++;
    if ({done_o, cpu_rst_o, in_ready_o, err_o} !== 4'b0110)
      $display("FAIL reload_from_done: done=%b cpu_rst=%b in_ready=%b err=%b, want 0 1 1 0",
               done_o, cpu_rst_o, in_ready_o, err_o);
    else n_pass++;
  endtask

  task automatic test_junk_gaps();
    clear_log();
    load_std_words();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_frame(2, 3, 1'b0);
    finish_frame();
    check_done("junk_done");
    idle(1);
    check_two_writes("junk_writes");
    pulse_reload();
  endtask

`ifdef NKMD_PROG_LOADER_CSUM_EN
  task automatic test_bad_csum();
    clear_log();
    load_std_words();
    send_frame(2, 0, 1'b0);
    send_byte(~last_csum);
    n_total++;
    if ({err_o, cpu_rst_o, done_o, in_ready_o} !== 4'b1100)
      $display("FAIL bad_csum: err=%b cpu_rst=%b done=%b in_ready=%b, want 1 1 0 0",
               err_o, cpu_rst_o, done_o, in_ready_o);
    else n_pass++;
    idle(1);
    check_two_writes("bad_csum_writes");
    pulse_reload();
    n_total++;
    if (err_o !== 1'b0 || in_ready_o !== 1'b1)
      $display("FAIL reload_from_err: err=%b in_ready=%b, want 0 1", err_o, in_ready_o);
    else n_pass++;
  endtask
`endif

  task automatic test_bad_len(input logic [7:0] hi, input logic [7:0] lo, input string name);
    clear_log();
    send_byte(8'hA5);
    send_byte(hi);
    send_byte(lo);
    n_total++;
    if ({err_o, cpu_rst_o, done_o, in_ready_o} !== 4'b1100)
      $display("FAIL %s: err=%b cpu_rst=%b done=%b in_ready=%b, want 1 1 0 0",
               name, err_o, cpu_rst_o, done_o, in_ready_o);
    else n_pass++;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    idle(1);
    n_total++;
    if (wr_addr_q.size() != 0)
      $display("FAIL %s_no_write: writes=%0d, want 0", name, wr_addr_q.size());
    else n_pass++;
    pulse_reload();
  endtask

  task automatic test_max_len();
    clear_log();
    for (int i = 0; i < 1024; i++) frame_words[i] = 32'(i) ^ 32'h5A000000;
    send_frame(1024, 0, 1'b0);
    finish_frame();
    check_done("max_len_done");
    idle(1);
    n_total++;
    if (wr_addr_q.size() != 1024)
      $display("FAIL max_len_count: writes=%0d, want 1024", wr_addr_q.size());
    else if (wr_addr_q[1023] !== 10'd1023 || wr_data_q[1023] !== 32'h5A0003FF || wr_addr_q[0] !== 10'd0)
      $display("FAIL max_len_last: addr=%0d data=%h, want 1023 5a0003ff",
               wr_addr_q[1023], wr_data_q[1023]);
    else n_pass++;
    pulse_reload();
  endtask

  task automatic test_reload_partial();
    clear_log();
    load_std_words();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02);
    pulse_reload();
    send_byte(8'h03); send_byte(8'h04);
    idle(1);
    n_total++;
    if (wr_addr_q.size() != 0 || in_ready_o !== 1'b1 || cpu_rst_o !== 1'b1)
      $display("FAIL reload_partial: writes=%0d in_ready=%b cpu_rst=%b, want 0 1 1",
               wr_addr_q.size(), in_ready_o, cpu_rst_o);
    else n_pass++;
    // Magic coinciding with reload must be dropped, so the rest of the frame is junk.
    in_data_i = 8'hA5; in_valid_i = 1'b1; reload_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0; reload_i = 1'b0;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
    idle(1);
    n_total++;
    if (wr_addr_q.size() != 0 || done_o !== 1'b0 || in_ready_o !== 1'b1)
      $display("FAIL reload_drops_byte: writes=%0d done=%b in_ready=%b, want 0 0 1",
               wr_addr_q.size(), done_o, in_ready_o);
    else n_pass++;
    send_frame(2, 0, 1'b0);
    finish_frame();
    check_done("after_reload_done");
    idle(1);
    check_two_writes("after_reload_writes");
    pulse_reload();
  endtask

  task automatic test_async_reset();
    clear_log();
    load_std_words();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({in_ready_o, prog_we_o, prog_addr_o, prog_data_o, cpu_rst_o, done_o, err_o} !== RESET_VEC)
      $display("FAIL async_reset: got %h, want %h",
               {in_ready_o, prog_we_o, prog_addr_o, prog_data_o, cpu_rst_o, done_o, err_o}, RESET_VEC);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    send_frame(2, 0, 1'b0);
    finish_frame();
    check_done("post_reset_done");
    idle(1);
    check_two_writes("post_reset_writes");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_junk_gaps();
`ifdef NKMD_PROG_LOADER_CSUM_EN
    test_bad_csum();
`endif
    test_bad_len(8'h00, 8'h00, "len_zero");
    test_bad_len(8'h04, 8'h01, "len_over");
    test_max_len();
    test_reload_partial();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
